clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
- Mode and sequencing controller for the minutes/seconds counter datapath of the digital clock.
- Divides the system clock into a one-second advance pulse in RUN mode.
- Converts two debounced push-buttons into a RUN → SET_MIN → SET_SEC mode cycle and single-cycle increment pulses.
- Drives a blink flag for the display digits being set.
- Sits between the button debouncers and the counter/display path.

Parameters:
- TICK_DIV, 100000000: clk cycles per run_tick (one second at 100 MHz); must be ≥ 2.
- BLINK_DIV, 50000000: clk cycles per blink toggle in set modes; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  debounced mode button, level, active-high.
- btn_up  in  1  debounced increment button, level, active-high.
- run_tick  out  1  one-cycle pulse; counter advances one second.
- inc_min  out  1  one-cycle pulse; counter increments minutes (mod 60, no carry).
- inc_sec  out  1  one-cycle pulse; counter increments seconds (mod 60, no carry into minutes).
- mode  out  2  00 RUN, 01 SET_MIN, 10 SET_SEC (11 never driven).
- blink  out  1  display blank/flash flag for the digits being set.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - mode=RUN; run_tick=inc_min=inc_sec=blink=0.
  - Tick and blink counters cleared to 0.
  - Button history registers set to 1, so a button held through reset release produces no pulse.
- **Edge detect:**
  - Each rising clk edge samples btn_x into btn_x_q.
  - A rise is btn_x=1 and btn_x_q=0 at that edge.
  - All outputs are registered. An input that goes high before edge k acts at edge k and is visible from k until k+1.
  - A held button yields exactly one rise; a new rise requires a release of at least one cycle.
- **FSM, on a btn_mode rise:** RUN→SET_MIN, SET_MIN→SET_SEC, SET_SEC→RUN.
- **btn_up rise:**
  - SET_MIN: inc_min=1 for one cycle.
  - SET_SEC: inc_sec=1 for one cycle.
  - RUN: ignored.
- **Simultaneous btn_mode and btn_up rise:** the mode change wins, no increment is issued, and the btn_up rise is consumed.
- **Tick counter** (width $clog2(TICK_DIV)):
  - Counts only in RUN.
  - At an edge where cnt==TICK_DIV-1: cnt←0 and run_tick←1. Otherwise cnt←cnt+1 and run_tick←0.
  - Held at 0 in set modes; run_tick=0 in set modes.
  - Entering RUN starts the count from 0, so the first run_tick is visible after TICK_DIV edges. For example, if mode becomes RUN at edge e, run_tick is high from e+TICK_DIV to e+TICK_DIV+1.
- **Blink:**
  - RUN: blink=0 and blink counter=0.
  - On the edge entering SET_MIN or SET_SEC: blink←1 and counter←0.
  - In a set mode: at counter==BLINK_DIV-1 the counter wraps to 0 and blink toggles.
  - SET_MIN→SET_SEC restarts the phase with blink=1.
- **Mutual exclusion:** at most one of run_tick, inc_min, inc_sec is high in any cycle.
- **Reset mid-operation:** immediate return to the reset state regardless of mode or pending counts; no pulse is emitted on release.

Test Plan (TICK_DIV=5, BLINK_DIV=3):
- **Tick timing:**
  - Stimulus: release reset, buttons low, run 20 cycles.
  - Required: run_tick high in cycles 5, 10, 15, 20 after release, each one cycle wide; mode=00 throughout.
- **Mode cycle:**
  - Stimulus: three btn_mode presses, each held 4 cycles with 4 cycles released between.
  - Required: mode goes 00→01→10→00, each change one edge after the rise.
  - Required: no run_tick while mode≠00; first run_tick exactly 5 cycles after mode returns to 00.
- **Increments:**
  - Stimulus: in SET_MIN, two btn_up presses, one of them held 10 cycles.
  - Required: exactly two inc_min pulses and no inc_sec.
  - Stimulus: in SET_SEC, one btn_up press.
  - Required: one inc_sec pulse.
  - Stimulus: one btn_up press in RUN.
  - Required: no pulse.
- **Simultaneous rise:**
  - Stimulus: in SET_MIN, btn_mode and btn_up rise on the same edge.
  - Required: mode=10 and inc_min=inc_sec=0 in all cycles.
- **Blink:**
  - Stimulus: enter SET_MIN.
  - Required: blink=1 for 3 cycles, then 0 for 3, then 1 for 3.
  - Stimulus: press btn_mode.
  - Required: blink=1 on the edge entering SET_SEC with a fresh 3-cycle phase; blink=0 immediately on return to RUN.
- **Reset:**
  - Stimulus: hold btn_up and btn_mode high, assert reset asynchronously mid-cycle in SET_SEC, then release.
  - Required: mode=00 and all pulses 0 without waiting for a clk edge.
  - Required: no mode change and no pulse after release until a button is released and pressed again.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode/sequencing controller for the clock's min:sec datapath: one-second tick,
// RUN -> SET_MIN -> SET_SEC mode cycle, button increment pulses and set-mode blink.
module clock_mode_ctrl #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       run_tick,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_SEC = 2'b10
  } mode_e;

  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  mode_e               state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic                run_tick_q, run_tick_d;
  logic                inc_min_q, inc_min_d;
  logic                inc_sec_q, inc_sec_d;
  logic                btn_mode_q, btn_up_q;
  logic                mode_rise, up_rise;

  assign mode_rise = btn_mode & ~btn_mode_q;
  assign up_rise   = btn_up & ~btn_up_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = '0;
    run_tick_d  = 1'b0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;

    if (mode_rise) begin
      unique case (state_q)
        MODE_RUN:     state_d = MODE_SET_MIN;
        MODE_SET_MIN: state_d = MODE_SET_SEC;
        default:      state_d = MODE_RUN;
      endcase
    end

    // Counting only while staying in RUN makes each RUN entry start from 0.
    if (state_q == MODE_RUN && state_d == MODE_RUN) begin
      if (tick_cnt_q == TICK_LAST) run_tick_d = 1'b1;
      else                         tick_cnt_d = tick_cnt_q + 1'b1;
    end

    // A mode change on the same edge swallows the increment request.
    inc_min_d = up_rise & ~mode_rise & (state_q == MODE_SET_MIN);
    inc_sec_d = up_rise & ~mode_rise & (state_q == MODE_SET_SEC);

    if (state_d != MODE_RUN) begin
      if (state_d != state_q) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MODE_RUN;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      run_tick_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
      // NOTE: history resets to 1 so a button held across reset release
      // is not mistaken for a fresh press.
      btn_mode_q  <= 1'b1;
      btn_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      run_tick_q  <= run_tick_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
      btn_mode_q  <= btn_mode;
      btn_up_q    <= btn_up;
    end
  end

  assign run_tick = run_tick_q;
  assign inc_min  = inc_min_q;
  assign inc_sec  = inc_sec_q;
  assign mode     = state_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with TICK_DIV=5, BLINK_DIV=3; outputs are
// sampled 1 time unit after each rising edge.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       run_tick;
  logic       inc_min;
  logic       inc_sec;
  logic [1:0] mode;
  logic       blink;

  int total = 0;
  int bad   = 0;
  int n_tick, n_min, n_sec;

  clock_mode_ctrl #(.TICK_DIV(5), .BLINK_DIV(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .run_tick (run_tick),
    .inc_min  (inc_min),
    .inc_sec  (inc_sec),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_tick = 0;
    n_min  = 0;
    n_sec  = 0;
  endtask

  // Drive buttons, advance one edge, sample, accumulate pulses.
  task automatic cycle(input logic m, input logic u);
    btn_mode = m;
    btn_up   = u;
    @(posedge clk);
    #1;
    n_tick += int'(run_tick);
    n_min  += int'(inc_min);
    n_sec  += int'(inc_sec);
    check("pulse_mutex", 32'($countones({run_tick, inc_min, inc_sec}) <= 1), 32'd1);
  endtask

  logic [1:0] mode_seq [3];

  initial begin
    mode_seq[0] = 2'b01;
    mode_seq[1] = 2'b10;
    mode_seq[2] = 2'b00;
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    clear_counts();

    #3;
    check("rst_mode",  32'(mode), 32'd0);
    check("rst_pulse", 32'({run_tick, inc_min, inc_sec, blink}), 32'd0);

    // Tick timing: pulses at edges 5, 10, 15, 20 after release.
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b0);
      check($sformatf("tick_%0d", i), 32'(run_tick), 32'((i % 5) == 0));
      check("tick_mode", 32'(mode), 32'd0);
    end

    // Mode cycle: 4 held / 4 released per press; blink pattern 1,1,1,0,0,0,1,1.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        cycle(j < 4, 1'b0);
        check($sformatf("mcyc_mode_%0d_%0d", k, j), 32'(mode), 32'(mode_seq[k]));
        if (k < 2) begin
          check($sformatf("mcyc_tick_%0d_%0d", k, j), 32'(run_tick), 32'd0);
          check($sformatf("mcyc_blink_%0d_%0d", k, j), 32'(blink), 32'(((j / 3) % 2) == 0));
        end else begin
          check($sformatf("mcyc_tick_run_%0d", j), 32'(run_tick), 32'(j == 5));
          check($sformatf("mcyc_blink_run_%0d", j), 32'(blink), 32'd0);
        end
      end
    end

    // Increments in SET_MIN: one short press, one held 10 cycles.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("inc_setmin_mode", 32'(mode), 32'd1);
    clear_counts();
    cycle(1'b0, 1'b1);
    check("inc_min_first", 32'(inc_min), 32'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("inc_min_count",     32'(n_min),  32'd2);
    check("inc_min_sec_count", 32'(n_sec),  32'd0);
    check("inc_min_tick",      32'(n_tick), 32'd0);

    // Increment in SET_SEC.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("inc_setsec_mode", 32'(mode), 32'd2);
    clear_counts();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("inc_sec_count",     32'(n_sec), 32'd1);
    check("inc_sec_min_count", 32'(n_min), 32'd0);

    // btn_up in RUN is ignored.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("inc_run_mode", 32'(mode), 32'd0);
    check("inc_run_blink", 32'(blink), 32'd0);
    clear_counts();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("inc_run_pulses", 32'(n_min + n_sec), 32'd0);

    // Simultaneous rise in SET_MIN: mode wins, up rise consumed; both kept held.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("simul_pre_mode", 32'(mode), 32'd1);
    clear_counts();
    cycle(1'b1, 1'b1);
    check("simul_mode", 32'(mode), 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("simul_mode_held", 32'(mode),          32'd2);
    check("simul_pulses",    32'(n_min + n_sec), 32'd0);

    // Asynchronous reset mid-cycle in SET_SEC with both buttons held.
    #3 reset = 1'b0;
    #1;
    check("async_rst_mode",  32'(mode), 32'd0);
    check("async_rst_pulse", 32'({run_tick, inc_min, inc_sec, blink}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1);
      check("post_rst_mode", 32'(mode), 32'd0);
    end
    check("post_rst_pulses", 32'(n_tick + n_min + n_sec), 32'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("repress_mode", 32'(mode),  32'd1);
    check("repress_blink", 32'(blink), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
